// File: rtl/strip_trig_pkg.sv
// Shared constants, FSM state and frame field layout for the strip trigger receiver.
package strip_trig_pkg;

   localparam int unsigned FRAME_BITS = 13;
   localparam int unsigned BCID_W     = 12;
   localparam int unsigned PHI_W      = 5;
   localparam int unsigned BAND_W     = 8;
   localparam int unsigned BIT_CNT_W  = 4;

   // Bit offsets inside the 13-bit lane shift registers (bit 12 = first bit on the wire)
   localparam int unsigned PAD_BIT  = 0;
   localparam int unsigned BCID_LSB = 1;
   localparam int unsigned PHI_LSB  = 8;
   localparam int unsigned BAND_LSB = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DRAIN = 2'd2
   } state_e;

   typedef struct packed {
      logic [BCID_W-1:0] bcid;
      logic              pad;
      logic [PHI_W-1:0]  phi_id;
      logic [BAND_W-1:0] bandid;
   } frame_t;

   function automatic frame_t unpack_frame(input logic [FRAME_BITS-1:0] sr0,
                                           input logic [FRAME_BITS-1:0] sr1);
      frame_t f;
      f.bcid   = sr0[BCID_LSB +: BCID_W];
      f.pad    = sr0[PAD_BIT];
      f.phi_id = sr1[PHI_LSB +: PHI_W];
      f.bandid = sr1[BAND_LSB +: BAND_W];
      return f;
   endfunction

endpackage

// File: rtl/strip_trig_sync.sv
// N-flop multi-bit synchronizer for the raw trigger link lanes.
module strip_trig_sync #(
   parameter int unsigned STAGES = 2,
   parameter int unsigned WIDTH  = 3
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge clk) begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) begin
         sync_q[i] <= sync_q[i-1];
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/strip_trigger_rx.sv
// Strip trigger link receiver: deframes 13-bit d0/d1 bursts, flags framing errors, counts frames.
module strip_trigger_rx
   import strip_trig_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CHECK_SEQ   = 1,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                 clk640,
   input  logic                 reset,
   input  logic                 trig_en,
   input  logic                 trig_d0,
   input  logic                 trig_d1,
   input  logic                 clr_cnt,
   output logic                 frame_valid,
   output logic [BCID_W-1:0]    bcid,
   output logic [PHI_W-1:0]     phi_id,
   output logic [BAND_W-1:0]    bandid,
   output logic                 err_short,
   output logic                 err_long,
   output logic                 err_pad,
   output logic                 seq_err,
   output logic [CNT_WIDTH-1:0] frame_cnt,
   output logic [CNT_WIDTH-1:0] err_cnt
);

   logic [2:0] sync_s;
   logic       en_s, d0_s, d1_s, en_p_q;

   state_e                state_q, state_d;
   logic [BIT_CNT_W-1:0]  bitcnt_q, bitcnt_d;
   logic [FRAME_BITS-1:0] sr0_q, sr0_d, sr1_q, sr1_d;
   logic                  good_c, short_c, long_c, pad_c;
   logic                  pend_good_q, pend_short_q, pend_long_q, pend_pad_q;
   logic                  armed_q;
   frame_t                frame_c;

   strip_trig_sync #(.STAGES(SYNC_STAGES), .WIDTH(3)) u_sync (
      .clk (clk640),
      .d_i ({trig_en, trig_d0, trig_d1}),
      .q_o (sync_s)
   );

   assign en_s    = sync_s[2];
   assign d0_s    = sync_s[1];
   assign d1_s    = sync_s[0];
   assign frame_c = unpack_frame(sr0_q, sr1_q);

   // Previous enable sample; left unreset so a link already enabled at reset release lands in DRAIN
   always_ff @(posedge clk640) begin
      en_p_q <= en_s;
   end

   always_ff @(posedge clk640) begin
      if (reset) begin
         state_q      <= IDLE;
         bitcnt_q     <= '0;
         sr0_q        <= '0;
         sr1_q        <= '0;
         pend_good_q  <= 1'b0;
         pend_short_q <= 1'b0;
         pend_long_q  <= 1'b0;
         pend_pad_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         sr0_q        <= sr0_d;
         sr1_q        <= sr1_d;
         pend_good_q  <= good_c;
         pend_short_q <= short_c;
         pend_long_q  <= long_c;
         pend_pad_q   <= pad_c;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      sr0_d    = sr0_q;
      sr1_d    = sr1_q;
      good_c   = 1'b0;
      short_c  = 1'b0;
      long_c   = 1'b0;
      pad_c    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (en_s && !en_p_q) begin
               sr0_d    = {sr0_q[FRAME_BITS-2:0], d0_s};
               sr1_d    = {sr1_q[FRAME_BITS-2:0], d1_s};
               bitcnt_d = BIT_CNT_W'(1);
               state_d  = SHIFT;
            end else if (en_s) begin
               state_d = DRAIN;
            end
         end
         SHIFT: begin
            if (bitcnt_q < BIT_CNT_W'(FRAME_BITS)) begin
               if (en_s) begin
                  sr0_d    = {sr0_q[FRAME_BITS-2:0], d0_s};
                  sr1_d    = {sr1_q[FRAME_BITS-2:0], d1_s};
                  bitcnt_d = bitcnt_q + BIT_CNT_W'(1);
               end else begin
                  short_c = 1'b1;
                  state_d = IDLE;
               end
            end else if (en_s) begin
               long_c  = 1'b1;
               state_d = DRAIN;
            end else begin
               // Shift registers stay intact one more cycle, so the next burst may start at once
               state_d = IDLE;
               pad_c   = frame_c.pad;
               good_c  = !frame_c.pad;
            end
         end
         DRAIN: begin
            if (!en_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs, band-sequence check and saturating statistics
   always_ff @(posedge clk640) begin
      if (reset) begin
         frame_valid <= 1'b0;
         bcid        <= '0;
         phi_id      <= '0;
         bandid      <= '0;
         err_short   <= 1'b0;
         err_long    <= 1'b0;
         err_pad     <= 1'b0;
         seq_err     <= 1'b0;
         armed_q     <= 1'b0;
         frame_cnt   <= '0;
         err_cnt     <= '0;
      end else begin
         frame_valid <= pend_good_q;
         err_short   <= pend_short_q;
         err_long    <= pend_long_q;
         err_pad     <= pend_pad_q;
         seq_err     <= 1'b0;
         if (pend_good_q) begin
            bcid   <= frame_c.bcid;
            phi_id <= frame_c.phi_id;
            bandid <= frame_c.bandid;
            if ((CHECK_SEQ != 0) && armed_q &&
                (frame_c.bandid[3:0] != (bandid[3:0] + 4'd1))) begin
               seq_err <= 1'b1;
            end
         end

         if (clr_cnt)          armed_q <= 1'b0;
         else if (pend_good_q) armed_q <= 1'b1;

         if (clr_cnt) begin
            frame_cnt <= '0;
         end else if (frame_valid && (frame_cnt != {CNT_WIDTH{1'b1}})) begin
            frame_cnt <= frame_cnt + CNT_WIDTH'(1);
         end

         if (clr_cnt) begin
            err_cnt <= '0;
         end else if ((err_short || err_long || err_pad || seq_err) &&
                      (err_cnt != {CNT_WIDTH{1'b1}})) begin
            err_cnt <= err_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_strip_trigger_rx.sv
// Directed bench for strip_trigger_rx: vector table plus back-to-back, reset and saturation sequences.
module tb_strip_trigger_rx;

   logic clk640 = 1'b0;
   logic reset, trig_en, trig_d0, trig_d1, clr_cnt;

   logic        frame_valid, err_short, err_long, err_pad, seq_err;
   logic [11:0] bcid;
   logic [4:0]  phi_id;
   logic [7:0]  bandid;
   logic [15:0] frame_cnt, err_cnt;

   logic        s_frame_valid, s_err_short, s_err_long, s_err_pad, s_seq_err;
   logic [11:0] s_bcid;
   logic [4:0]  s_phi_id;
   logic [7:0]  s_bandid;
   logic [3:0]  s_frame_cnt, s_err_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk640 = ~clk640;

   strip_trigger_rx dut (
      .clk640(clk640), .reset(reset), .trig_en(trig_en), .trig_d0(trig_d0), .trig_d1(trig_d1),
      .clr_cnt(clr_cnt), .frame_valid(frame_valid), .bcid(bcid), .phi_id(phi_id), .bandid(bandid),
      .err_short(err_short), .err_long(err_long), .err_pad(err_pad), .seq_err(seq_err),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   strip_trigger_rx #(.SYNC_STAGES(2), .CHECK_SEQ(0), .CNT_WIDTH(4)) dut_s (
      .clk640(clk640), .reset(reset), .trig_en(trig_en), .trig_d0(trig_d0), .trig_d1(trig_d1),
      .clr_cnt(clr_cnt), .frame_valid(s_frame_valid), .bcid(s_bcid), .phi_id(s_phi_id),
      .bandid(s_bandid), .err_short(s_err_short), .err_long(s_err_long), .err_pad(s_err_pad),
      .seq_err(s_seq_err), .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
   );

   // Cycle counter and pulse monitors (sampled on the falling edge)
   int cyc = 0;
   int n_fv = 0, n_short = 0, n_long = 0, n_pad = 0, n_seq = 0, n_seq_s = 0;
   int last_ev_cyc = -100;
   logic [7:0] log_band [32];
   logic       log_seq  [32];

   always @(posedge clk640) cyc <= cyc + 1;

   always @(negedge clk640) begin
      if (frame_valid) begin
         log_band[n_fv % 32] = bandid;
         log_seq[n_fv % 32]  = seq_err;
         n_fv++;
      end
      if (frame_valid || err_short || err_pad) last_ev_cyc = cyc;
      if (err_short) n_short++;
      if (err_long)  n_long++;
      if (err_pad)   n_pad++;
      if (seq_err)   n_seq++;
      if (s_seq_err) n_seq_s++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk640);
      #1;
   endtask

   int burst_last_cyc = 0;

   // Drive one enable burst of len cycles, both lanes MSB first, zeros past bit 13
   task automatic burst(input logic [12:0] w0, input logic [12:0] w1, input int len);
      logic [12:0] s0, s1;
      s0 = w0;
      s1 = w1;
      for (int i = 0; i < len; i++) begin
         trig_en = 1'b1;
         trig_d0 = s0[12];
         trig_d1 = s1[12];
         s0 = s0 << 1;
         s1 = s1 << 1;
         tick();
      end
      trig_en = 1'b0;
      trig_d0 = 1'b0;
      trig_d1 = 1'b0;
      burst_last_cyc = cyc;
   endtask

   typedef struct {
      logic [12:0] w0;
      logic [12:0] w1;
      int          len;
      int          fv, sh, lg, pad, sq;
      int          lat;
      logic [11:0] bcid;
      logic [4:0]  phi;
      logic [7:0]  band;
      int          fcnt, ecnt;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int b_fv, b_sh, b_lg, b_pad, b_sq, b_sq_s;
      logic [7:0] seq_bands [4];
      bit seen;

      vecs[0] = '{13'h14B8, 13'h1503, 13, 1, 0, 0, 0, 0, 4, 12'hA5C, 5'h15, 8'h03, 1, 0};
      vecs[1] = '{13'h0AAA, 13'h0555,  9, 0, 1, 0, 0, 0, 4, 12'hA5C, 5'h15, 8'h03, 1, 1};
      vecs[2] = '{13'h1FFE, 13'h0001, 16, 0, 0, 1, 0, 0, 0, 12'hA5C, 5'h15, 8'h03, 1, 2};
      vecs[3] = '{13'h0246, 13'h0404, 13, 1, 0, 0, 0, 0, 4, 12'h123, 5'h04, 8'h04, 2, 2};
      vecs[4] = '{13'h0EEF, 13'h1F05, 13, 0, 0, 0, 1, 0, 4, 12'h123, 5'h04, 8'h04, 2, 3};
      vecs[5] = '{13'h1FFE, 13'h0015, 13, 1, 0, 0, 0, 0, 4, 12'hFFF, 5'h00, 8'h15, 3, 3};
      vecs[6] = '{13'h0000, 13'h1F07, 13, 1, 0, 0, 0, 1, 4, 12'h000, 5'h1F, 8'h07, 4, 4};
      seq_bands[0] = 8'h0E;
      seq_bands[1] = 8'h0F;
      seq_bands[2] = 8'h00;
      seq_bands[3] = 8'h05;

      reset = 1'b1; trig_en = 1'b0; trig_d0 = 1'b0; trig_d1 = 1'b0; clr_cnt = 1'b0;
      repeat (4) tick();
      reset = 1'b0;
      repeat (2) tick();

      chk("rst frame_valid", int'(frame_valid), 0);
      chk("rst bcid", int'(bcid), 0);
      chk("rst phi_id", int'(phi_id), 0);
      chk("rst bandid", int'(bandid), 0);
      chk("rst errors", int'({err_short, err_long, err_pad, seq_err}), 0);
      chk("rst frame_cnt", int'(frame_cnt), 0);
      chk("rst err_cnt", int'(err_cnt), 0);

      // Table: good, short, long, good-after-long, pad, in-sequence, out-of-sequence
      for (int v = 0; v < 7; v++) begin
         b_fv = n_fv; b_sh = n_short; b_lg = n_long; b_pad = n_pad; b_sq = n_seq;
         burst(vecs[v].w0, vecs[v].w1, vecs[v].len);
         repeat (10) tick();
         chk($sformatf("v%0d frame_valid pulses", v), n_fv - b_fv, vecs[v].fv);
         chk($sformatf("v%0d err_short pulses", v), n_short - b_sh, vecs[v].sh);
         chk($sformatf("v%0d err_long pulses", v), n_long - b_lg, vecs[v].lg);
         chk($sformatf("v%0d err_pad pulses", v), n_pad - b_pad, vecs[v].pad);
         chk($sformatf("v%0d seq_err pulses", v), n_seq - b_sq, vecs[v].sq);
         if (vecs[v].lat != 0)
            chk($sformatf("v%0d latency", v), last_ev_cyc - burst_last_cyc, vecs[v].lat);
         chk($sformatf("v%0d bcid", v), int'(bcid), int'(vecs[v].bcid));
         chk($sformatf("v%0d phi_id", v), int'(phi_id), int'(vecs[v].phi));
         chk($sformatf("v%0d bandid", v), int'(bandid), int'(vecs[v].band));
         chk($sformatf("v%0d frame_cnt", v), int'(frame_cnt), vecs[v].fcnt);
         chk($sformatf("v%0d err_cnt", v), int'(err_cnt), vecs[v].ecnt);
      end

      // Clear counters (disarms the checker), then four frames with 1-cycle gaps
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      tick();
      chk("clr frame_cnt", int'(frame_cnt), 0);
      chk("clr err_cnt", int'(err_cnt), 0);

      b_fv = n_fv; b_sq = n_seq; b_sq_s = n_seq_s;
      for (int k = 0; k < 4; k++) begin
         burst({12'(12'h100 + k), 1'b0}, {5'h0A, seq_bands[k]}, 13);
         tick();
      end
      repeat (10) tick();
      chk("b2b frame_valid pulses", n_fv - b_fv, 4);
      chk("b2b seq_err pulses", n_seq - b_sq, 1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("b2b band %0d", k), int'(log_band[(b_fv + k) % 32]), int'(seq_bands[k]));
      end
      chk("b2b seq_err on 8'h05", int'(log_seq[(b_fv + 3) % 32]), 1);
      chk("b2b seq_err disabled", n_seq_s - b_sq_s, 0);
      chk("b2b bcid", int'(bcid), 12'h103);
      chk("b2b frame_cnt", int'(frame_cnt), 4);
      chk("b2b err_cnt", int'(err_cnt), 1);

      // Reset asserted at bit 6 of a burst, released while the enable is still high
      b_fv = n_fv; b_sh = n_short; b_lg = n_long; b_pad = n_pad;
      trig_en = 1'b1; trig_d0 = 1'b1; trig_d1 = 1'b1;
      repeat (6) tick();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      repeat (6) tick();
      trig_en = 1'b0; trig_d0 = 1'b0; trig_d1 = 1'b0;
      repeat (10) tick();
      chk("midrst pulses", (n_fv - b_fv) + (n_short - b_sh) + (n_long - b_lg) + (n_pad - b_pad), 0);
      chk("midrst bcid", int'(bcid), 0);
      chk("midrst phi_id", int'(phi_id), 0);
      chk("midrst bandid", int'(bandid), 0);
      chk("midrst frame_cnt", int'(frame_cnt), 0);
      chk("midrst err_cnt", int'(err_cnt), 0);

      // 17 frames: 4-bit counter saturates, bands 0..16 include the F->0 wrap
      for (int k = 0; k < 17; k++) begin
         burst({12'(k), 1'b0}, {5'h01, 8'(k)}, 13);
         tick();
      end
      repeat (10) tick();
      chk("sat frame_cnt 4-bit", int'(s_frame_cnt), 15);
      chk("sat frame_cnt 16-bit", int'(frame_cnt), 17);
      chk("sat err_cnt (wrap legal)", int'(err_cnt), 0);
      chk("sat bandid", int'(bandid), 8'h10);

      // clr_cnt in the same cycle as frame_valid wins over the increment
      burst({12'h0AB, 1'b0}, {5'h02, 8'h11}, 13);
      seen = 1'b0;
      for (int t = 0; t < 12 && !seen; t++) begin
         if (frame_valid) seen = 1'b1;
         else tick();
      end
      chk("clrhit frame_valid seen", int'(seen), 1);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      repeat (5) tick();
      chk("clrhit frame_cnt", int'(frame_cnt), 0);
      chk("clrhit frame_cnt 4-bit", int'(s_frame_cnt), 0);
      chk("clrhit bcid", int'(bcid), 12'h0AB);
      chk("seq_err never on CHECK_SEQ=0", n_seq_s, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
